// File: rtl/replay_sequencer.sv
// rtl/replay_sequencer.sv - instant-replay snapshot BRAM sequencer
//
// Records one snapshot per frame into a circular BRAM during play and, after
// game over, plays the stored frames back oldest-first at a selectable rate.
//
// Ports:
//   CLK          system clock
//   RST_BTN      synchronous active-high reset
//   mode         0 = start menu, 1 = game
//   endgame      game-over level
//   reply        replay request level (rising edge acts)
//   frame_tick   one-cycle pulse per frame
//   speed        playback divider, one advance per speed+1 frame_ticks
//   ram_enable   BRAM read enable (playback)
//   write_enable BRAM write strobe (recording)
//   address      BRAM address
//   frame_count  number of valid stored frames, saturates at DEPTH
//   playing      high during playback
//   replay_done  one-cycle pulse at end of playback
//   disp_sel     display source: 00 menu, 01 game, 10 game over, 11 replay
module replay_sequencer #(
    parameter int ADDR_BITS = 9
) (
    input  logic                 CLK,
    input  logic                 RST_BTN,
    input  logic                 mode,
    input  logic                 endgame,
    input  logic                 reply,
    input  logic                 frame_tick,
    input  logic [3:0]           speed,
    output logic                 ram_enable,
    output logic                 write_enable,
    output logic [ADDR_BITS-1:0] address,
    output logic [ADDR_BITS:0]   frame_count,
    output logic                 playing,
    output logic                 replay_done,
    output logic [1:0]           disp_sel
);

    localparam logic [ADDR_BITS-1:0] ONE_A = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   ONE_C = {{ADDR_BITS{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, RECORD, HOLD, PLAYBACK, DONE} state_t;

    state_t                 state, state_n;
    logic [ADDR_BITS-1:0]   wr_ptr, wr_ptr_n;
    logic [ADDR_BITS-1:0]   rd_ptr, rd_ptr_n;
    logic [ADDR_BITS-1:0]   waddr_q, waddr_n;
    logic [ADDR_BITS:0]     count_n;
    logic [ADDR_BITS:0]     played, played_n;
    logic [3:0]             div_cnt, div_cnt_n;
    logic                   we_n, done_n;
    logic                   reply_q, reply_rise;
    logic [ADDR_BITS-1:0]   start;

    assign reply_rise = reply & ~reply_q;
    // The MSB of frame_count is set only when the buffer is full; the
    // oldest frame then sits at the next write position.
    assign start = frame_count[ADDR_BITS] ? wr_ptr : '0;

    always_comb begin
        state_n   = state;
        wr_ptr_n  = wr_ptr;
        rd_ptr_n  = rd_ptr;
        count_n   = frame_count;
        played_n  = played;
        div_cnt_n = div_cnt;
        waddr_n   = '0;
        we_n      = 1'b0;
        done_n    = 1'b0;
        if (!mode) begin
            state_n  = IDLE;
            wr_ptr_n = '0;
            count_n  = '0;
        end else begin
            case (state)
                IDLE: state_n = endgame ? HOLD : RECORD;
                RECORD: begin
                    // Game over wins over a coincident tick: no write.
                    if (endgame) begin
                        state_n = HOLD;
                    end else if (frame_tick) begin
                        we_n     = 1'b1;
                        waddr_n  = wr_ptr;
                        wr_ptr_n = wr_ptr + ONE_A;
                        if (!frame_count[ADDR_BITS])
                            count_n = frame_count + ONE_C;
                    end
                end
                HOLD: begin
                    if (!endgame) begin
                        state_n  = RECORD;
                        wr_ptr_n = '0;
                        count_n  = '0;
                    end else if (reply_rise && frame_count != '0) begin
                        state_n   = PLAYBACK;
                        rd_ptr_n  = start;
                        played_n  = ONE_C;
                        div_cnt_n = '0;
                    end
                end
                PLAYBACK: begin
                    if (!endgame) begin
                        state_n  = RECORD;
                        wr_ptr_n = '0;
                        count_n  = '0;
                    end else if (reply_rise) begin
                        rd_ptr_n  = start;
                        played_n  = ONE_C;
                        div_cnt_n = '0;
                    end else if (frame_tick) begin
                        if (div_cnt == speed) begin
                            div_cnt_n = '0;
                            if (played < frame_count) begin
                                rd_ptr_n = rd_ptr + ONE_A;
                                played_n = played + ONE_C;
                            end else begin
                                state_n = DONE;
                                done_n  = 1'b1;
                            end
                        end else begin
                            div_cnt_n = div_cnt + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (!endgame) begin
                        state_n  = RECORD;
                        wr_ptr_n = '0;
                        count_n  = '0;
                    end else if (reply_rise) begin
                        state_n   = PLAYBACK;
                        rd_ptr_n  = start;
                        played_n  = ONE_C;
                        div_cnt_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_BTN) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            waddr_q      <= '0;
            frame_count  <= '0;
            played       <= '0;
            div_cnt      <= '0;
            write_enable <= 1'b0;
            replay_done  <= 1'b0;
            reply_q      <= 1'b0;
        end else begin
            state        <= state_n;
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            waddr_q      <= waddr_n;
            frame_count  <= count_n;
            played       <= played_n;
            div_cnt      <= div_cnt_n;
            write_enable <= we_n;
            replay_done  <= done_n;
            reply_q      <= reply;
        end
    end

    assign ram_enable = (state == PLAYBACK);
    assign playing    = (state == PLAYBACK);
    // waddr_q is zero except in the cycle of a write strobe.
    assign address    = ram_enable ? rd_ptr : waddr_q;

    always_comb begin
        disp_sel = 2'b00;
        case (state)
            RECORD:   disp_sel = 2'b01;
            HOLD:     disp_sel = 2'b10;
            PLAYBACK: disp_sel = 2'b11;
            DONE:     disp_sel = 2'b10;
            default:  disp_sel = 2'b00;
        endcase
    end

endmodule
